// File: rtl/antirebote_banco_if.sv
`default_nettype none
// ============================================================================
// antirebote_banco_if : raw inputs / clear in, debounced levels and events out
// Revision 1.0
// ============================================================================
interface antirebote_banco_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] raw_in;
    logic            clr;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] toggle_out;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] long_toggle;

    modport master (
        output raw_in, clr,
        input  level_out, press_pulse, release_pulse, toggle_out, long_pulse, long_toggle
    );

    modport slave (
        input  raw_in, clr,
        output level_out, press_pulse, release_pulse, toggle_out, long_pulse, long_toggle
    );
endinterface
`default_nettype wire

// File: rtl/antirebote_banco.sv
`default_nettype none
// ============================================================================
// antirebote_banco : bank of independent debouncers with press/release/long events
// Revision 1.0
// ============================================================================
module antirebote_banco #(
    parameter int              N_CH     = 4,
    parameter int              DEB_CYC  = 10000,
    parameter int              LONG_CYC = 125000000,
    parameter int              CNT_W    = 27,
    parameter logic [N_CH-1:0] INV      = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    antirebote_banco_if.slave  bus
);
    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_CHK_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             w_raw;
        logic             sync_q, s_q;
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] dcnt_q, dcnt_d;
        logic [CNT_W-1:0] lcnt_q, lcnt_d;
        logic             fired_q, fired_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             tog_q, tog_d;
        logic             lp_q, lp_d;
        logic             lt_q, lt_d;
        logic             w_rise, w_fall, w_held, w_long;

        assign w_raw = bus.raw_in[gi] ^ INV[gi];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q  <= 1'b0;
                s_q     <= 1'b0;
                state_q <= S_LOW;
                dcnt_q  <= '0;
                lcnt_q  <= '0;
                fired_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                tog_q   <= 1'b0;
                lp_q    <= 1'b0;
                lt_q    <= 1'b0;
            end else begin
                sync_q  <= w_raw;
                s_q     <= sync_q;
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                lcnt_q  <= lcnt_d;
                fired_q <= fired_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                tog_q   <= tog_d;
                lp_q    <= lp_d;
                lt_q    <= lt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            case (state_q)
                S_LOW: begin
                    if (s_q) begin
                        state_d = S_CHK_HIGH;
                        dcnt_d  = c_one;
                    end
                end
                S_CHK_HIGH: begin
                    if (!s_q) begin
                        state_d = S_LOW;
                        dcnt_d  = '0;
                    end else if (dcnt_q == c_deb_last) begin
                        state_d = S_HIGH;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d  = dcnt_q + c_one;
                    end
                end
                S_HIGH: begin
                    if (!s_q) begin
                        state_d = S_CHK_LOW;
                        dcnt_d  = c_one;
                    end
                end
                S_CHK_LOW: begin
                    if (s_q) begin
                        state_d = S_HIGH;
                        dcnt_d  = '0;
                    end else if (dcnt_q == c_deb_last) begin
                        state_d = S_LOW;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d  = dcnt_q + c_one;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    dcnt_d  = '0;
                end
            endcase
        end

        // Long-press tracking survives CHK_LOW bounces; only a fresh rise resets it.
        always_comb begin
            w_rise  = (state_q == S_CHK_HIGH) && s_q && (dcnt_q == c_deb_last);
            w_fall  = (state_q == S_CHK_LOW) && !s_q && (dcnt_q == c_deb_last);
            w_held  = (state_q == S_HIGH) || (state_q == S_CHK_LOW);
            w_long  = w_held && (lcnt_q == c_long_last) && !fired_q;
            level_d = w_rise ? 1'b1 : (w_fall ? 1'b0 : level_q);
            press_d = w_rise;
            rel_d   = w_fall;
            tog_d   = bus.clr ? 1'b0 : (tog_q ^ w_fall);
            lp_d    = w_long;
            lt_d    = bus.clr ? 1'b0 : (lt_q ^ w_long);
            if (w_rise) begin
                lcnt_d = '0;
            end else if (w_held && (lcnt_q != c_long_last)) begin
                lcnt_d = lcnt_q + c_one;
            end else begin
                lcnt_d = lcnt_q;
            end
            fired_d = (state_d == S_LOW) ? 1'b0 : (fired_q | w_long);
        end

        assign bus.level_out[gi]     = level_q;
        assign bus.press_pulse[gi]   = press_q;
        assign bus.release_pulse[gi] = rel_q;
        assign bus.toggle_out[gi]    = tog_q;
        assign bus.long_pulse[gi]    = lp_q;
        assign bus.long_toggle[gi]   = lt_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_antirebote_banco.sv
`default_nettype none
// ============================================================================
// tb_antirebote_banco : scoreboard bench, 2 channels, ch1 inverted
// Revision 1.0
// ============================================================================
module tb_antirebote_banco;
    typedef struct {
        int          cyc;
        logic [11:0] snap;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    ev_t  sb_q[$];
    ev_t  mon_e;
    logic [11:0] mon_o;

    antirebote_banco_if #(.N_CH(2)) bus ();

    antirebote_banco #(
        .N_CH     (2),
        .DEB_CYC  (4),
        .LONG_CYC (16),
        .CNT_W    (8),
        .INV      (2'b10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // snapshot layout: {long_toggle, toggle_out, level_out, long_pulse, release_pulse, press_pulse}
    function automatic logic [11:0] outs();
        return {bus.long_toggle, bus.toggle_out, bus.level_out,
                bus.long_pulse, bus.release_pulse, bus.press_pulse};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic expect_ev(input int dcyc, input logic [11:0] snap);
        ev_t e;
        e.cyc  = cyc + dcyc;
        e.snap = snap;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        mon_o = outs();
        if (mon_o[5:0] != 6'b0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, mon_o);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.snap !== mon_o) begin
                    n_bad++;
                    $display("FAIL event got cyc=%0d snap=%b want cyc=%0d snap=%b",
                             cyc, mon_o, mon_e.cyc, mon_e.snap);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.raw_in = 2'b10;
        bus.clr = 1'b0;
        wait_cyc(3);
        check("reset_state", outs(), 12'b0);
        reset = 1'b1;
        wait_cyc(8);

        // single press with long hold, then release
        bus.raw_in[0] = 1'b1;
        expect_ev(6,  12'b00_00_01_00_00_01);
        expect_ev(22, 12'b01_00_01_01_00_00);
        wait_cyc(7);
        check("press_dropped", {6'b0, outs()[7:6], outs()[1:0], 2'b0}, {6'b0, 2'b01, 2'b00, 2'b0});
        wait_cyc(23);
        bus.raw_in[0] = 1'b0;
        expect_ev(6,  12'b01_01_00_00_01_00);
        wait_cyc(12);

        // short glitch rejected
        bus.raw_in[0] = 1'b1;
        wait_cyc(3);
        bus.raw_in[0] = 1'b0;
        wait_cyc(10);
        check("glitch_level", outs(), 12'b01_01_00_00_00_00);

        bus.clr = 1'b1;
        wait_cyc(1);
        bus.clr = 1'b0;
        check("clr_toggles", outs(), 12'b0);

        // two press/release pairs, then a release coinciding with clr
        bus.raw_in[0] = 1'b1; expect_ev(6, 12'b00_00_01_00_00_01); wait_cyc(8);
        bus.raw_in[0] = 1'b0; expect_ev(6, 12'b00_01_00_00_01_00); wait_cyc(8);
        bus.raw_in[0] = 1'b1; expect_ev(6, 12'b00_01_01_00_00_01); wait_cyc(8);
        bus.raw_in[0] = 1'b0; expect_ev(6, 12'b00_00_00_00_01_00); wait_cyc(8);
        bus.raw_in[0] = 1'b1; expect_ev(6, 12'b00_00_01_00_00_01); wait_cyc(8);
        bus.raw_in[0] = 1'b0; expect_ev(6, 12'b00_00_00_00_01_00); wait_cyc(5);
        bus.clr = 1'b1;
        wait_cyc(1);
        bus.clr = 1'b0;
        wait_cyc(6);

        // inverted channel
        bus.raw_in[1] = 1'b0; expect_ev(6, 12'b00_00_10_00_00_10); wait_cyc(8);
        bus.raw_in[1] = 1'b1; expect_ev(6, 12'b00_10_00_00_10_00); wait_cyc(8);

        // simultaneous events on both channels
        bus.raw_in = 2'b01; expect_ev(6, 12'b00_10_11_00_00_11); wait_cyc(8);
        bus.raw_in = 2'b10; expect_ev(6, 12'b00_01_00_00_11_00); wait_cyc(8);

        // reset during CHK_HIGH
        bus.raw_in[0] = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        #1;
        check("async_reset_chk_high", outs(), 12'b0);
        wait_cyc(2);
        reset = 1'b1;
        expect_ev(6, 12'b00_00_01_00_00_01);
        wait_cyc(16);

        // reset mid long-press count
        reset = 1'b0;
        #1;
        check("async_reset_long", outs(), 12'b0);
        bus.raw_in[0] = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(30);
        check("idle_after_reset", outs(), 12'b0);

        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event got=none want cyc=%0d snap=%b", mon_e.cyc, mon_e.snap);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
